divider_ctrl: RTL and testbench
===============================

DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 26, width of the period counter and divisor.
REQ-002 SHALL have parameter DIV_DEFAULT, default 500000, divisor loaded at reset (50 MHz -> 100 Hz).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run enable; 1 = count, 0 = stop.
REQ-006 SHALL have port cfg_valid  input  1  a new divisor is offered.
REQ-007 SHALL have port cfg_div  input  CNT_W  offered divisor N, in clk cycles per output period.
REQ-008 SHALL have port cfg_ready  output  1  the block can accept a divisor.
REQ-009 SHALL have port tick  output  1  one-cycle strobe in the last cycle of each period.
REQ-010 SHALL have port clk_out  output  1  divided square wave (see REQ-027).
REQ-011 SHALL have port busy  output  1  high in RUN or PEND.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse when an illegal divisor is rejected.

Function
REQ-013 SHALL hold registers state {STOP, RUN, PEND}, cnt[CNT_W], div_reg[CNT_W] and pend_reg[CNT_W].
REQ-014 SHALL complete a transfer when cfg_valid && cfg_ready in the same cycle.
REQ-015 SHALL drive cfg_ready = 1 in STOP and RUN, and 0 in PEND.
REQ-016 SHALL discard a transferred cfg_div < 2, leave div_reg and state unchanged, and pulse cfg_err high on the next cycle.
REQ-017 In STOP, a legal transfer SHALL load div_reg on the next edge; cnt stays at 0.
REQ-018 The transition STOP -> RUN SHALL occur on the edge where en = 1; cnt = 0 in the first RUN cycle.
REQ-019 In RUN or PEND with en = 1, cnt SHALL increment every cycle and wrap to 0 after cnt == div_reg-1.
REQ-020 tick SHALL be 1 exactly in cycles where state is RUN or PEND and cnt == div_reg-1.
REQ-021 A legal transfer in RUN while cnt != div_reg-1 SHALL store pend_reg and move to PEND.
REQ-022 A legal transfer in RUN while cnt == div_reg-1 SHALL load div_reg at that wrap; state stays RUN.
REQ-023 In PEND, at the wrap edge the block SHALL set div_reg <= pend_reg and return to RUN, with no truncated or extended period.
REQ-024 With en = 0 in RUN, the block SHALL go to STOP next edge and set cnt <= 0.
REQ-025 With en = 0 in PEND, the block SHALL go to STOP and set div_reg <= pend_reg immediately.
REQ-026 Writing cfg_div equal to div_reg SHALL behave as a normal transfer; no special-case.
REQ-027 clk_out SHALL be 1 while busy && cnt < div_reg - div_reg/2 (integer division), and 0 otherwise; odd N gives the extra cycle high.
REQ-028 The block SHALL register all outputs or decode them only from registered state; no combinational path from inputs to outputs except cfg_ready, which depends on state only.

Reset
REQ-029 On rst = 1 at an edge: state = STOP, cnt = 0, div_reg = DIV_DEFAULT, pend_reg = 0, tick = 0, clk_out = 0, busy = 0, cfg_err = 0, cfg_ready = 1.
REQ-030 rst SHALL override en and cfg_valid in the same cycle; a pending divisor is lost on reset mid-operation.

Configuration
REQ-031 Macro DIVIDER_CTRL_CLKOUT_EN SHALL, when defined, include port clk_out and its decode per REQ-027.
REQ-032 When DIVIDER_CTRL_CLKOUT_EN is undefined, port clk_out and its logic SHALL be absent; all other behaviour is unchanged.

Verification (bench overrides DIV_DEFAULT = 10)
REQ-033 Reset, then en = 1 -> tick every 10 cycles, first at cycle 10 after en; clk_out 5 high / 5 low; busy = 1.
REQ-034 In RUN, with cnt = 3, offer cfg_div = 4 -> cfg_ready = 0 until wrap; the current period completes at 10, then ticks every 4 cycles; clk_out 2/2.
REQ-035 Offer cfg_div = 1, then cfg_div = 0 -> each is accepted, cfg_err pulses one cycle, and the tick period stays 10.
REQ-036 Offer cfg_div = 7 in the cycle cnt == 9 -> the next period is 7 cycles; clk_out 4 high / 3 low.
REQ-037 en = 0 while in PEND with pend = 6, then en = 1 -> cnt restarts at 0 and the period is 6.
REQ-038 Assert rst at cnt = 5 in PEND -> next cycle is STOP, div_reg = 10, and all outputs are at their reset values.

Source files
------------

// File: rtl/divider_ctrl.sv
// divider_ctrl: programmable clock divider with a ready/valid divisor port.
// A new divisor takes effect only on a period boundary, so no period is ever
// truncated or stretched; a divisor offered mid-period is parked in pend_reg.
// Optional feature: define DIVIDER_CTRL_CLKOUT_EN to add the clk_out square
// wave output and its decode.
module divider_ctrl #(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
`ifdef DIVIDER_CTRL_CLKOUT_EN
  output logic             clk_out,
`endif
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] pend_reg, pend_next;
  logic             cfg_err_reg, cfg_err_next;

  logic             xfer;
  logic             legal;
  logic             at_wrap;

  // A divisor below 2 cannot produce a period with a distinct last cycle.
  assign xfer    = cfg_valid && cfg_ready;
  assign legal   = (cfg_div >= CNT_W'(2));
  assign at_wrap = (cnt_reg == div_reg - CNT_W'(1));

  // Outputs decode only registered state; cfg_ready depends on state alone.
  assign cfg_ready = (state_reg != ST_PEND);
  assign busy      = (state_reg != ST_STOP);
  assign tick      = busy && at_wrap;
  assign cfg_err   = cfg_err_reg;

`ifdef DIVIDER_CTRL_CLKOUT_EN
  // High for the first ceil(N/2) cycles of each period, so odd N is high longer.
  assign clk_out = busy && (cnt_reg < (div_reg - (div_reg >> 1)));
`endif

  // Register update with synchronous reset; reset discards any pending divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_STOP;
      cnt_reg     <= '0;
      div_reg     <= CNT_W'(DIV_DEFAULT);
      pend_reg    <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      pend_reg    <= pend_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  // Next-state, counter and divisor-handover decisions.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_next     = div_reg;
    pend_next    = pend_reg;
    cfg_err_next = xfer && !legal;

    case (state_reg)
      ST_STOP: begin
        cnt_next = '0;
        if (xfer && legal) begin
          div_next = cfg_div;
        end
        if (en) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!en) begin
          // Stopping: nothing is mid-period any more, so a divisor applies now.
          state_next = ST_STOP;
          cnt_next   = '0;
          if (xfer && legal) begin
            div_next = cfg_div;
          end
        end else begin
          cnt_next = at_wrap ? '0 : cnt_reg + CNT_W'(1);
          if (xfer && legal) begin
            if (at_wrap) begin
              div_next = cfg_div;
            end else begin
              pend_next  = cfg_div;
              state_next = ST_PEND;
            end
          end
        end
      end

      ST_PEND: begin
        if (!en) begin
          state_next = ST_STOP;
          cnt_next   = '0;
          div_next   = pend_reg;
        end else if (at_wrap) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          div_next   = pend_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_STOP;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Testbench for divider_ctrl. The reference model describes the divider as
// "current period length, cycles left in it, optional queued divisor" and
// is compared every cycle against the observable outputs.
module tb_divider_ctrl;

  localparam int CNT_W   = 26;
  localparam int DIV_DEF = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             tick;
  logic             busy;
  logic             cfg_err;
`ifdef DIVIDER_CTRL_CLKOUT_EN
  logic             clk_out;
`endif

  divider_ctrl #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(DIV_DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .tick     (tick),
`ifdef DIVIDER_CTRL_CLKOUT_EN
    .clk_out  (clk_out),
`endif
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  bit m_run  = 1'b0;
  int m_per  = DIV_DEF;
  int m_left = 0;
  int m_pend[$];
  bit m_err  = 1'b0;

  function automatic logic co_now();
`ifdef DIVIDER_CTRL_CLKOUT_EN
    return clk_out;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4:0] obs_vec();
    return {tick, busy, cfg_ready, cfg_err, co_now()};
  endfunction

  function automatic logic [4:0] exp_vec();
    logic co;
    co = 1'b0;
`ifdef DIVIDER_CTRL_CLKOUT_EN
    co = m_run && ((m_per - m_left) < (m_per - m_per / 2));
`endif
    return {m_run && (m_left == 1), m_run, (m_pend.size() == 0), m_err, co};
  endfunction

  function automatic string q2s(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d,", q[i])};
    return s;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit r, input bit e, input bit v, input int d);
    bit acc;
    bit bad;
    rst       = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = CNT_W'(d);
    @(posedge clk);
    acc = v && (m_pend.size() == 0);
    bad = acc && (d < 2);
    if (r) begin
      m_run  = 1'b0;
      m_per  = DIV_DEF;
      m_left = 0;
      m_pend.delete();
      m_err  = 1'b0;
    end else begin
      m_err = bad;
      if (!m_run) begin
        if (acc && !bad) m_per = d;
        if (e) begin
          m_run  = 1'b1;
          m_left = m_per;
        end
      end else if (!e) begin
        m_run = 1'b0;
        if (m_pend.size() != 0) m_per = m_pend.pop_front();
        else if (acc && !bad) m_per = d;
      end else if (m_left == 1) begin
        if (m_pend.size() != 0) m_per = m_pend.pop_front();
        else if (acc && !bad) m_per = d;
        m_left = m_per;
      end else begin
        if (acc && !bad) m_pend.push_back(d);
        m_left = m_left - 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 5);
    checks++;
    if (obs_vec() !== 5'b00100)
      $display("FAIL reset_outputs got %b want %b", obs_vec(), 5'b00100);
    else passed++;
    step(0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_idle got %b want %b", obs_vec(), exp_vec());
    else passed++;
    $display("test_reset: outputs %b after reset", obs_vec());
  endtask

  task automatic test_run();
    int tk[$];
    int hi;
    hi = 0;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL run_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (tick) tk.push_back(k);
      if (k <= 10 && co_now()) hi++;
    end
    checks++;
    if (q2s(tk) != "10,20,30,")
      $display("FAIL run_ticks got %s want 10,20,30,", q2s(tk));
    else passed++;
    checks++;
    if (busy !== 1'b1) $display("FAIL run_busy got %b want 1", busy);
    else passed++;
`ifdef DIVIDER_CTRL_CLKOUT_EN
    checks++;
    if (hi !== 5) $display("FAIL run_clkout_high got %0d want 5", hi);
    else passed++;
`endif
    $display("test_run: ticks at %s clk_out high %0d", q2s(tk), hi);
  endtask

  task automatic test_pend();
    int tk[$];
    int hi;
    hi = 0;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 28; k++) begin
      step(0, 1, (k == 15), 4);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL pend_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (k == 15) begin
        checks++;
        if (cfg_ready !== 1'b0) $display("FAIL pend_ready got %b want 0", cfg_ready);
        else passed++;
      end
      if (tick) tk.push_back(k);
      if (k >= 21 && k <= 24 && co_now()) hi++;
    end
    checks++;
    if (q2s(tk) != "10,20,24,28,")
      $display("FAIL pend_ticks got %s want 10,20,24,28,", q2s(tk));
    else passed++;
`ifdef DIVIDER_CTRL_CLKOUT_EN
    checks++;
    if (hi !== 2) $display("FAIL pend_clkout_high got %0d want 2", hi);
    else passed++;
`endif
    $display("test_pend: offered 4 at cnt 3, ticks at %s", q2s(tk));
  endtask

  task automatic test_bad_div();
    int tk[$];
    logic want_err;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 1, (k == 5 || k == 12), (k == 5) ? 1 : 0);
      want_err = (k == 5 || k == 12);
      checks++;
      if (cfg_err !== want_err)
        $display("FAIL bad_div_err k=%0d got %b want %b", k, cfg_err, want_err);
      else passed++;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL bad_div_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (tick) tk.push_back(k);
    end
    checks++;
    if (q2s(tk) != "10,20,30,")
      $display("FAIL bad_div_ticks got %s want 10,20,30,", q2s(tk));
    else passed++;
    $display("test_bad_div: divisors 1 and 0 rejected, ticks at %s", q2s(tk));
  endtask

  task automatic test_div_at_wrap();
    int tk[$];
    int hi;
    hi = 0;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      step(0, 1, (k == 11), 7);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL wrap_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (tick) tk.push_back(k);
      if (k >= 11 && k <= 17 && co_now()) hi++;
    end
    checks++;
    if (q2s(tk) != "10,17,24,")
      $display("FAIL wrap_ticks got %s want 10,17,24,", q2s(tk));
    else passed++;
`ifdef DIVIDER_CTRL_CLKOUT_EN
    checks++;
    if (hi !== 4) $display("FAIL wrap_clkout_high got %0d want 4", hi);
    else passed++;
`endif
    $display("test_div_at_wrap: offered 7 at cnt 9, ticks at %s", q2s(tk));
  endtask

  task automatic test_stop_pend();
    int tk[$];
    step(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, !(k == 6 || k == 7), (k == 4), 6);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stop_pend_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (tick) tk.push_back(k);
    end
    checks++;
    if (q2s(tk) != "13,19,")
      $display("FAIL stop_pend_ticks got %s want 13,19,", q2s(tk));
    else passed++;
    $display("test_stop_pend: stop in PEND with 6, ticks at %s", q2s(tk));
  endtask

  task automatic test_rst_pend();
    int tk[$];
    step(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step((k == 7), (k != 7), (k == 2), 6);
      if (k == 7) begin
        checks++;
        if (obs_vec() !== 5'b00100)
          $display("FAIL rst_pend_outputs got %b want %b", obs_vec(), 5'b00100);
        else passed++;
      end
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL rst_pend_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
      else passed++;
      if (tick) tk.push_back(k);
    end
    checks++;
    if (q2s(tk) != "17,")
      $display("FAIL rst_pend_ticks got %s want 17,", q2s(tk));
    else passed++;
    $display("test_rst_pend: reset in PEND, ticks at %s", q2s(tk));
  endtask

  task automatic test_random();
    int errs;
    bit r, e, v;
    int d;
    errs = 0;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 600; k++) begin
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 3) == 0);
      d = $urandom_range(0, 12);
      step(r, e, v, d);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random_cycle k=%0d got %b want %b", k, obs_vec(), exp_vec());
        errs++;
      end else passed++;
    end
    $display("test_random: 600 cycles, %0d differences", errs);
  endtask

  initial begin
    test_reset();
    test_run();
    test_bad_div();
    test_pend();
    test_div_at_wrap();
    test_stop_pend();
    test_rst_pend();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
